// File: rtl/fetch_pc_stage.sv
// ============================================================================
// Module      : fetch_pc_stage
// Description : Fetch-stage PC register plus the IF/ID pipeline register for
//               a 5-stage RV32I core. Sequences a one-cycle boot after reset,
//               honours hazard-unit stall/flush and taken-branch redirects.
// Revision    : 1.0 - initial release
// ----------------------------------------------------------------------------
// Ports:
//   clk          core clock, all state on rising edge
//   rst          asynchronous active-high reset
//   StallF       hold PC register
//   StallD       hold IF/ID register
//   FlushD       squash IF/ID contents (beats StallD)
//   PCSrcE       redirect fetch to PC_T (beats StallF)
//   PC_T[31:0]   branch/jump target from Execute
//   InstrF[31:0] instruction-memory read data for PCF
//   PCF[31:0]    current fetch address (the PC register itself)
//   InstrD[31:0] instruction to Decode
//   PCD[31:0]    PC of InstrD
//   PCPlus4D     PCD + 4
//   ValidD       InstrD is a real fetched instruction
//   MisalignErr  sticky misaligned-target flag
// Configuration macro:
//   FETCH_MISALIGN_TRAP_EN - when defined, a redirect to a target with
//   PC_T[1:0]!=0 freezes fetch, sets MisalignErr and parks the FSM in HALT
//   until reset. When undefined, target bits [1:0] are forced to zero.
// ============================================================================
`default_nettype none
`timescale 1ns/1ps

module fetch_pc_stage #(
  parameter logic [31:0] RESET_VECTOR = 32'h0000_0000,
  parameter logic [31:0] NOP_INSTR    = 32'h0000_0013
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        StallF,
  input  logic        StallD,
  input  logic        FlushD,
  input  logic        PCSrcE,
  input  logic [31:0] PC_T,
  input  logic [31:0] InstrF,
  output logic [31:0] PCF,
  output logic [31:0] InstrD,
  output logic [31:0] PCD,
  output logic [31:0] PCPlus4D,
  output logic        ValidD,
  output logic        MisalignErr
);

  typedef enum logic [1:0] {
    S_BOOT = 2'd0,
    S_RUN  = 2'd1,
    S_HALT = 2'd2
  } state_t;

  state_t      state_q, state_n;
  logic [31:0] pc_n;
  logic [31:0] instr_n;
  logic [31:0] pcd_n;
  logic [31:0] pcp4_n;
  logic        valid_n;
  logic [31:0] pc_plus4;

  // Natural 32-bit wrap: 0xFFFF_FFFC + 4 = 0, silently.
  assign pc_plus4 = PCF + 32'd4;

`ifdef FETCH_MISALIGN_TRAP_EN
  logic misalign_q, misalign_n;
  logic target_misaligned;
  assign target_misaligned = (PC_T[1:0] != 2'b00);
  assign MisalignErr       = misalign_q;
`else
  assign MisalignErr = 1'b0;
`endif

  // --------------------------------------------------------------------------
  // Next-state / next-register logic
  // --------------------------------------------------------------------------
  always_comb begin
    state_n = state_q;
    pc_n    = PCF;
    instr_n = InstrD;
    pcd_n   = PCD;
    pcp4_n  = PCPlus4D;
    valid_n = ValidD;
`ifdef FETCH_MISALIGN_TRAP_EN
    misalign_n = misalign_q;
`endif

    case (state_q)
      S_BOOT: begin
        // Hold the reset vector one edge so instruction memory sees it before
        // the first real capture; all hazard inputs are ignored here.
        pc_n    = RESET_VECTOR;
        instr_n = NOP_INSTR;
        pcd_n   = 32'd0;
        pcp4_n  = 32'd0;
        valid_n = 1'b0;
        state_n = S_RUN;
      end

      S_RUN: begin
        // PC register: redirect beats stall.
        if (PCSrcE) begin
`ifdef FETCH_MISALIGN_TRAP_EN
          if (target_misaligned) begin
            misalign_n = 1'b1;
            state_n    = S_HALT;
          end else begin
            pc_n = PC_T;
          end
`else
          pc_n = PC_T & 32'hFFFF_FFFC;
`endif
        end else if (!StallF) begin
          pc_n = pc_plus4;
        end

        // IF/ID register: flush beats stall.
        if (FlushD) begin
          instr_n = NOP_INSTR;
          pcd_n   = 32'd0;
          pcp4_n  = 32'd0;
          valid_n = 1'b0;
        end else if (!StallD) begin
          instr_n = InstrF;
          pcd_n   = PCF;
          pcp4_n  = pc_plus4;
          valid_n = 1'b1;
        end

`ifdef FETCH_MISALIGN_TRAP_EN
        // Nothing fetched on the trapping edge may reach Decode.
        if (PCSrcE && target_misaligned) begin
          instr_n = NOP_INSTR;
          pcd_n   = 32'd0;
          pcp4_n  = 32'd0;
          valid_n = 1'b0;
        end
`endif
      end

      S_HALT: begin
        // Frozen PC, bubble every edge; only reset leaves this state.
        instr_n = NOP_INSTR;
        pcd_n   = 32'd0;
        pcp4_n  = 32'd0;
        valid_n = 1'b0;
      end

      default: begin
        state_n = S_BOOT;
      end
    endcase
  end

  // --------------------------------------------------------------------------
  // State and pipeline registers
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= S_BOOT;
      PCF      <= RESET_VECTOR;
      InstrD   <= NOP_INSTR;
      PCD      <= 32'd0;
      PCPlus4D <= 32'd0;
      ValidD   <= 1'b0;
    end else begin
      state_q  <= state_n;
      PCF      <= pc_n;
      InstrD   <= instr_n;
      PCD      <= pcd_n;
      PCPlus4D <= pcp4_n;
      ValidD   <= valid_n;
    end
  end

`ifdef FETCH_MISALIGN_TRAP_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      misalign_q <= 1'b0;
    end else begin
      misalign_q <= misalign_n;
    end
  end
`endif

endmodule

`default_nettype wire

// File: tb/tb_fetch_pc_stage.sv
// ============================================================================
// Module      : tb_fetch_pc_stage
// Description : Directed self-checking bench for fetch_pc_stage. Instruction
//               memory is modelled as a fixed function of the fetch address.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none
`timescale 1ns/1ps

module tb_fetch_pc_stage;

  localparam logic [31:0] NOP = 32'h0000_0013;

  logic        clk = 1'b0;
  logic        rst;
  logic        StallF, StallD, FlushD, PCSrcE;
  logic [31:0] PC_T, InstrF;
  logic [31:0] PCF, InstrD, PCD, PCPlus4D;
  logic        ValidD, MisalignErr;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  // Instruction memory: swap halves and tag, so address 0 reads 0x33, not NOP.
  function automatic logic [31:0] imem(input logic [31:0] a);
    return {a[15:0], a[31:16]} ^ 32'h0000_0033;
  endfunction

  assign InstrF = imem(PCF);

  fetch_pc_stage dut (
    .clk(clk), .rst(rst),
    .StallF(StallF), .StallD(StallD), .FlushD(FlushD), .PCSrcE(PCSrcE),
    .PC_T(PC_T), .InstrF(InstrF),
    .PCF(PCF), .InstrD(InstrD), .PCD(PCD), .PCPlus4D(PCPlus4D),
    .ValidD(ValidD), .MisalignErr(MisalignErr)
  );

  // Advance one edge and sample 1 ns later.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    StallF = 0; StallD = 0; FlushD = 0; PCSrcE = 0; PC_T = 32'h0;
  endtask

  // Leaves rst released; the next edge is the BOOT edge.
  task automatic do_reset();
    rst = 1'b1;
    step();
    step();
    rst = 1'b0;
  endtask

  // Redirect fetch to an aligned address (one edge).
  task automatic go_to(input logic [31:0] a);
    PCSrcE = 1; PC_T = a;
    step();
    PCSrcE = 0;
  endtask

  task automatic test_reset();
    clear_inputs();
    do_reset();
    total++; if (PCF !== 32'h0) begin bad++; $display("FAIL rst_pcf got=%h exp=%h", PCF, 32'h0); end
    total++; if (InstrD !== NOP) begin bad++; $display("FAIL rst_instrd got=%h exp=%h", InstrD, NOP); end
    total++; if (PCD !== 32'h0 || PCPlus4D !== 32'h0) begin bad++; $display("FAIL rst_pcd got=%h/%h exp=0/0", PCD, PCPlus4D); end
    total++; if (ValidD !== 1'b0 || MisalignErr !== 1'b0) begin bad++; $display("FAIL rst_flags got=%b%b exp=00", ValidD, MisalignErr); end
    step(); // BOOT edge
    total++; if (PCF !== 32'h0 || ValidD !== 1'b0) begin bad++; $display("FAIL boot_edge got pcf=%h v=%b exp=0/0", PCF, ValidD); end
    step();
    total++; if (PCF !== 32'h4) begin bad++; $display("FAIL run1_pcf got=%h exp=%h", PCF, 32'h4); end
    total++; if (PCD !== 32'h0 || InstrD !== imem(32'h0) || PCPlus4D !== 32'h4 || ValidD !== 1'b1)
      begin bad++; $display("FAIL run1_d got pcd=%h i=%h p4=%h v=%b exp=0/%h/4/1", PCD, InstrD, PCPlus4D, ValidD, imem(32'h0)); end
    repeat (15) step();
    total++; if (PCF !== 32'h40 || PCD !== 32'h3C) begin bad++; $display("FAIL seq_0x40 got pcf=%h pcd=%h exp=40/3c", PCF, PCD); end
    // Asynchronous reset mid-run: effect visible before any clock edge.
    rst = 1'b1;
    #1;
    total++; if (PCF !== 32'h0 || ValidD !== 1'b0 || InstrD !== NOP || PCD !== 32'h0)
      begin bad++; $display("FAIL async_rst got pcf=%h v=%b i=%h pcd=%h exp=0/0/13/0", PCF, ValidD, InstrD, PCD); end
    step();
    rst = 1'b0;
    step(); // BOOT edge
    total++; if (PCF !== 32'h0 || ValidD !== 1'b0) begin bad++; $display("FAIL reboot_edge got pcf=%h v=%b exp=0/0", PCF, ValidD); end
    step();
    total++; if (PCF !== 32'h4 || PCD !== 32'h0 || ValidD !== 1'b1 || InstrD !== imem(32'h0))
      begin bad++; $display("FAIL reboot_run got pcf=%h pcd=%h v=%b i=%h exp=4/0/1/%h", PCF, PCD, ValidD, InstrD, imem(32'h0)); end
  endtask

  task automatic test_boot_ignores_inputs();
    clear_inputs();
    PCSrcE = 1; PC_T = 32'h80; StallF = 1; FlushD = 1;
    do_reset();
    step(); // BOOT edge: inputs ignored
    total++; if (PCF !== 32'h0 || ValidD !== 1'b0) begin bad++; $display("FAIL boot_ignore got pcf=%h v=%b exp=0/0", PCF, ValidD); end
    FlushD = 0;
    step(); // RUN: redirect applies
    total++; if (PCF !== 32'h80 || PCD !== 32'h0 || ValidD !== 1'b1)
      begin bad++; $display("FAIL boot_then_run got pcf=%h pcd=%h v=%b exp=80/0/1", PCF, PCD, ValidD); end
    clear_inputs();
  endtask

  task automatic test_wrap();
    go_to(32'hFFFF_FFF8);
    total++; if (PCF !== 32'hFFFF_FFF8) begin bad++; $display("FAIL wrap_redir got=%h exp=fffffff8", PCF); end
    step();
    total++; if (PCF !== 32'hFFFF_FFFC || PCD !== 32'hFFFF_FFF8) begin bad++; $display("FAIL wrap1 got pcf=%h pcd=%h exp=fffffffc/fffffff8", PCF, PCD); end
    step();
    total++; if (PCF !== 32'h0) begin bad++; $display("FAIL wrap2_pcf got=%h exp=0", PCF); end
    total++; if (PCD !== 32'hFFFF_FFFC || PCPlus4D !== 32'h0 || InstrD !== imem(32'hFFFF_FFFC))
      begin bad++; $display("FAIL wrap2_d got pcd=%h p4=%h i=%h exp=fffffffc/0/%h", PCD, PCPlus4D, InstrD, imem(32'hFFFF_FFFC)); end
    step();
    total++; if (PCF !== 32'h4 || PCD !== 32'h0 || PCPlus4D !== 32'h4) begin bad++; $display("FAIL wrap3 got pcf=%h pcd=%h p4=%h exp=4/0/4", PCF, PCD, PCPlus4D); end
  endtask

  task automatic test_redirect_flush();
    go_to(32'h20);
    PCSrcE = 1; FlushD = 1; PC_T = 32'h100;
    step();
    clear_inputs();
    total++; if (PCF !== 32'h100) begin bad++; $display("FAIL rf_pcf got=%h exp=100", PCF); end
    total++; if (InstrD !== NOP || ValidD !== 1'b0 || PCD !== 32'h0 || PCPlus4D !== 32'h0)
      begin bad++; $display("FAIL rf_bubble got i=%h v=%b pcd=%h p4=%h exp=13/0/0/0", InstrD, ValidD, PCD, PCPlus4D); end
    step();
    total++; if (PCD !== 32'h100 || ValidD !== 1'b1 || InstrD !== imem(32'h100) || PCPlus4D !== 32'h104 || PCF !== 32'h104)
      begin bad++; $display("FAIL rf_next got pcd=%h v=%b i=%h p4=%h pcf=%h exp=100/1/%h/104/104", PCD, ValidD, InstrD, PCPlus4D, PCF, imem(32'h100)); end
  endtask

  task automatic test_stall();
    go_to(32'hC);
    step();
    total++; if (PCF !== 32'h10 || PCD !== 32'hC) begin bad++; $display("FAIL st_setup got pcf=%h pcd=%h exp=10/c", PCF, PCD); end
    StallF = 1; StallD = 1;
    for (int i = 0; i < 3; i++) begin
      step();
      total++; if (PCF !== 32'h10 || PCD !== 32'hC || InstrD !== imem(32'hC) || PCPlus4D !== 32'h10 || ValidD !== 1'b1)
        begin bad++; $display("FAIL st_hold%0d got pcf=%h pcd=%h i=%h p4=%h v=%b exp=10/c/%h/10/1", i, PCF, PCD, InstrD, PCPlus4D, ValidD, imem(32'hC)); end
    end
    StallF = 0; StallD = 0;
    step();
    total++; if (PCF !== 32'h14 || PCD !== 32'h10) begin bad++; $display("FAIL st_release got pcf=%h pcd=%h exp=14/10", PCF, PCD); end
    StallF = 1; PCSrcE = 1; PC_T = 32'h200;
    step();
    clear_inputs();
    total++; if (PCF !== 32'h200 || PCD !== 32'h14) begin bad++; $display("FAIL st_redir_wins got pcf=%h pcd=%h exp=200/14", PCF, PCD); end
  endtask

  task automatic test_flush_beats_stall();
    StallD = 1; FlushD = 1;
    step();
    clear_inputs();
    total++; if (ValidD !== 1'b0 || InstrD !== NOP || PCD !== 32'h0 || PCPlus4D !== 32'h0)
      begin bad++; $display("FAIL fbs_bubble got v=%b i=%h pcd=%h p4=%h exp=0/13/0/0", ValidD, InstrD, PCD, PCPlus4D); end
    total++; if (PCF !== 32'h204) begin bad++; $display("FAIL fbs_pcf got=%h exp=204", PCF); end
  endtask

  task automatic test_misalign();
    go_to(32'h30);
    PCSrcE = 1; PC_T = 32'h102;
    step();
    clear_inputs();
`ifdef FETCH_MISALIGN_TRAP_EN
    total++; if (PCF !== 32'h30 || MisalignErr !== 1'b1 || ValidD !== 1'b0)
      begin bad++; $display("FAIL mis_trap got pcf=%h err=%b v=%b exp=30/1/0", PCF, MisalignErr, ValidD); end
    PCSrcE = 1; PC_T = 32'h400; StallD = 1;
    for (int i = 0; i < 3; i++) begin
      step();
      total++; if (PCF !== 32'h30 || MisalignErr !== 1'b1 || ValidD !== 1'b0 || InstrD !== NOP)
        begin bad++; $display("FAIL mis_halt%0d got pcf=%h err=%b v=%b i=%h exp=30/1/0/13", i, PCF, MisalignErr, ValidD, InstrD); end
    end
    clear_inputs();
    do_reset();
    total++; if (MisalignErr !== 1'b0 || PCF !== 32'h0) begin bad++; $display("FAIL mis_rst got err=%b pcf=%h exp=0/0", MisalignErr, PCF); end
    step();
    step();
    total++; if (PCF !== 32'h4 || ValidD !== 1'b1) begin bad++; $display("FAIL mis_rerun got pcf=%h v=%b exp=4/1", PCF, ValidD); end
`else
    total++; if (PCF !== 32'h100 || MisalignErr !== 1'b0) begin bad++; $display("FAIL mis_force got pcf=%h err=%b exp=100/0", PCF, MisalignErr); end
    PCSrcE = 1; PC_T = 32'h203;
    step();
    clear_inputs();
    total++; if (PCF !== 32'h200 || MisalignErr !== 1'b0 || PCD !== 32'h100)
      begin bad++; $display("FAIL mis_force2 got pcf=%h err=%b pcd=%h exp=200/0/100", PCF, MisalignErr, PCD); end
    step();
    total++; if (PCF !== 32'h204 || ValidD !== 1'b1) begin bad++; $display("FAIL mis_continue got pcf=%h v=%b exp=204/1", PCF, ValidD); end
`endif
  endtask

  initial begin
    rst = 1'b1;
    clear_inputs();
    test_reset();
    test_boot_ignores_inputs();
    test_wrap();
    test_redirect_flush();
    test_stall();
    test_flush_beats_stall();
    test_misalign();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/fetch_pc_stage.md
Name: fetch_pc_stage

Overview:
Fetch-stage PC register and IF/ID pipeline register for the 5-stage RV32I core. Consumes the branch/jump target (PC_T) from the target adder and the taken-branch select from Execute. Drives the instruction-memory address and presents PC, PC+4 and the fetched instruction to Decode. Honours hazard-unit stall/flush and sequences the post-reset boot cycle.

Parameters:
RESET_VECTOR, 32'h0000_0000, PC value loaded on reset.
NOP_INSTR, 32'h0000_0013, instruction injected into Decode on flush/bubble (addi x0,x0,0).

Ports:
clk  input  1  core clock, all state on rising edge
rst  input  1  asynchronous, active-high reset
StallF  input  1  hold PC register (hazard unit)
StallD  input  1  hold IF/ID register (hazard unit)
FlushD  input  1  squash IF/ID contents (hazard unit)
PCSrcE  input  1  1 = redirect fetch to PC_T
PC_T  input  32  branch/jump target from Execute
InstrF  input  32  instruction-memory read data for PCF (combinational read)
PCF  output  32  current fetch address to instruction memory
InstrD  output  32  instruction to Decode
PCD  output  32  PC of InstrD
PCPlus4D  output  32  PCD + 4
ValidD  output  1  1 = InstrD is a real fetched instruction
MisalignErr  output  1  sticky misaligned-target flag (see Optional Feature)

Behaviour:
- Reset (rst high, asynchronous, any cycle including mid-stall/redirect): PCF=RESET_VECTOR, InstrD=NOP_INSTR, PCD=0, PCPlus4D=0, ValidD=0, MisalignErr=0, FSM=BOOT.
- FSM states: BOOT, RUN, HALT (HALT reachable only with the optional feature).
- BOOT: lasts exactly one clock edge after rst deasserts. PCF holds RESET_VECTOR; IF/ID loads bubble (NOP_INSTR, ValidD=0). Stall/flush/PCSrcE are ignored. Next state RUN.
- RUN, PC update priority per edge: PCSrcE=1 -> PCF<=PC_T (overrides StallF); else StallF=1 -> hold; else PCF<=PCF+4.
- PCF+4 is computed mod 2^32: 32'hFFFF_FFFC wraps to 0, with no flag.
- RUN, IF/ID update priority per edge: FlushD=1 -> bubble (InstrD=NOP_INSTR, PCD=0, PCPlus4D=0, ValidD=0), overriding StallD; else StallD=1 -> hold all four; else InstrD<=InstrF, PCD<=PCF, PCPlus4D<=PCF+4, ValidD<=1.
- Latency: InstrF/PCF appear on the D outputs one edge after sampling. A redirect takes effect on PCF one edge after PCSrcE is sampled. The block does not auto-flush; the hazard unit asserts FlushD with PCSrcE.
- Simultaneous StallF=1 and StallD=0 is legal. Decode then receives the same PC again (duplicate); the hazard unit is responsible for not issuing this combination.
- All outputs are registered except PCF, which is the PC register itself.

Optional Feature:
Macro: FETCH_MISALIGN_TRAP_EN.
- Defined: in RUN, if PCSrcE=1 and PC_T[1:0]!=2'b00, PCF holds its value, MisalignErr<=1 (sticky), and FSM->HALT. In HALT, PCF is frozen, IF/ID loads a bubble every edge regardless of StallD/FlushD, and all inputs are ignored. Only rst exits HALT.
- Not defined: PC_T is loaded with bits[1:0] forced to 00. MisalignErr is tied to 0. HALT is unreachable.

Test Plan:
- Reset/boot: assert rst mid-run at PCF=0x40, release -> PCF=0x0 for the BOOT edge, ValidD=0. Next edge: PCD=0x0, InstrD=InstrF@0x0, ValidD=1, PCF=0x4.
- Sequential plus wrap: force PCF=0xFFFF_FFF8 via redirect, run 3 edges -> PCF sequence 0xFFFF_FFFC, 0x0, 0x4. PCPlus4D for PCD=0xFFFF_FFFC is 0x0.
- Redirect plus flush: at PCF=0x20, PCSrcE=1, FlushD=1, PC_T=0x100 -> next edge PCF=0x100, InstrD=0x0000_0013, ValidD=0, PCD=0. Following edge: PCD=0x100, ValidD=1.
- Stall: StallF=StallD=1 for 3 edges at PCF=0x10 -> PCF stays 0x10 and D outputs are unchanged. Deassert -> PCF=0x14. Then StallF=1 with PCSrcE=1, PC_T=0x200 -> PCF=0x200 (redirect wins).
- Flush beats stall: StallD=1, FlushD=1 -> bubble loaded, ValidD=0.
- Misaligned (with macro): PCSrcE=1, PC_T=0x102 at PCF=0x30 -> PCF stays 0x30, MisalignErr=1, ValidD=0 on all later edges, rst clears. Without macro: same stimulus -> PCF=0x100, MisalignErr=0.
